// File: rtl/iiitb_param_fifo.sv
// Single-clock FIFO with fill level, almost thresholds, flush and sticky error flags.
// Read data lands one cycle after an accepted read; full stalls writes unless a read frees a slot the same cycle.
module iiitb_param_fifo #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       write_Enable,
    input  logic                       read_Enable,
    input  logic                       clear_Error,
    input  logic [DATA_WIDTH-1:0]      buffer_Input,
    output logic [DATA_WIDTH-1:0]      buffer_Output,
    output logic                       data_Valid,
    output logic                       sig_Full,
    output logic                       sig_Empty,
    output logic                       sig_AlmostFull,
    output logic                       sig_AlmostEmpty,
    output logic [$clog2(DEPTH):0]     fill_Count,
    output logic                       err_Overflow,
    output logic                       err_Underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  ovf_evt;
    logic                  unf_evt;

    assign sig_Full        = (fill_Count == CW'(DEPTH));
    assign sig_Empty       = (fill_Count == '0);
    assign sig_AlmostFull  = (fill_Count >= CW'(AFULL_THRESH));
    assign sig_AlmostEmpty = (fill_Count <= CW'(AEMPTY_THRESH));

    // Flush masks both requests, so it can neither move data nor raise errors.
    assign rd_acc  = read_Enable && !sig_Empty && !flush;
    assign wr_acc  = write_Enable && (!sig_Full || rd_acc) && !flush;
    assign ovf_evt = write_Enable && sig_Full && !rd_acc && !flush;
    assign unf_evt = read_Enable && sig_Empty && !flush;

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr] <= buffer_Input;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_Count    <= '0;
            buffer_Output <= '0;
            data_Valid    <= 1'b0;
            err_Overflow  <= 1'b0;
            err_Underflow <= 1'b0;
        end else begin
            // A new error in the same cycle as clear_Error keeps the flag set.
            err_Overflow  <= ovf_evt | (err_Overflow & ~clear_Error);
            err_Underflow <= unf_evt | (err_Underflow & ~clear_Error);
            data_Valid    <= rd_acc;
            if (flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fill_Count <= '0;
            end else begin
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_acc) begin
                    rd_ptr        <= rd_ptr + 1'b1;
                    buffer_Output <= mem[rd_ptr];
                end
                if (wr_acc && !rd_acc) begin
                    fill_Count <= fill_Count + 1'b1;
                end else if (rd_acc && !wr_acc) begin
                    fill_Count <= fill_Count - 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_iiitb_param_fifo.sv
// Directed bench for iiitb_param_fifo at DATA_WIDTH=8, DEPTH=16, thresholds 12/4.
module tb_iiitb_param_fifo;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       write_Enable = 1'b0;
    logic       read_Enable = 1'b0;
    logic       clear_Error = 1'b0;
    logic [7:0] buffer_Input = 8'h00;
    logic [7:0] buffer_Output;
    logic       data_Valid;
    logic       sig_Full;
    logic       sig_Empty;
    logic       sig_AlmostFull;
    logic       sig_AlmostEmpty;
    logic [4:0] fill_Count;
    logic       err_Overflow;
    logic       err_Underflow;

    int total = 0;
    int bad = 0;

    iiitb_param_fifo #(
        .DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .write_Enable(write_Enable), .read_Enable(read_Enable),
        .clear_Error(clear_Error), .buffer_Input(buffer_Input),
        .buffer_Output(buffer_Output), .data_Valid(data_Valid),
        .sig_Full(sig_Full), .sig_Empty(sig_Empty),
        .sig_AlmostFull(sig_AlmostFull), .sig_AlmostEmpty(sig_AlmostEmpty),
        .fill_Count(fill_Count), .err_Overflow(err_Overflow),
        .err_Underflow(err_Underflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of requests; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic we, input logic re, input logic fl,
                        input logic ce, input logic [7:0] d);
        write_Enable = we;
        read_Enable  = re;
        flush        = fl;
        clear_Error  = ce;
        buffer_Input = d;
        @(posedge clock);
        #1;
        write_Enable = 1'b0;
        read_Enable  = 1'b0;
        flush        = 1'b0;
        clear_Error  = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_cnt"}, 32'(fill_Count), 0);
        chk({tag, "_empty"}, 32'(sig_Empty), 1);
        chk({tag, "_full"}, 32'(sig_Full), 0);
        chk({tag, "_ae"}, 32'(sig_AlmostEmpty), 1);
        chk({tag, "_af"}, 32'(sig_AlmostFull), 0);
        chk({tag, "_dv"}, 32'(data_Valid), 0);
        chk({tag, "_out"}, 32'(buffer_Output), 0);
        chk({tag, "_ovf"}, 32'(err_Overflow), 0);
        chk({tag, "_unf"}, 32'(err_Underflow), 0);
    endtask

    initial begin
        #2;
        chk_reset_state("rst");
        @(posedge clock);
        #2;
        reset = 1'b0;

        // Fill 1..16 and watch the thresholds
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0, 0, 8'(i));
            chk("fill_cnt", 32'(fill_Count), 32'(i));
            chk("fill_af", 32'(sig_AlmostFull), (i >= 12) ? 1 : 0);
            chk("fill_ae", 32'(sig_AlmostEmpty), (i <= 4) ? 1 : 0);
        end
        chk("full", 32'(sig_Full), 1);
        step(1, 0, 0, 0, 8'd99);
        chk("ovf_set", 32'(err_Overflow), 1);
        chk("ovf_cnt", 32'(fill_Count), 16);
        step(0, 0, 0, 1, 8'd0);
        chk("ovf_clr", 32'(err_Overflow), 0);

        // Drain in order
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 0, 0, 8'd0);
            chk("drain_out", 32'(buffer_Output), 32'(i));
            chk("drain_dv", 32'(data_Valid), 1);
            chk("drain_cnt", 32'(fill_Count), 32'(16 - i));
        end
        chk("drain_empty", 32'(sig_Empty), 1);
        step(0, 0, 0, 0, 8'd0);
        chk("idle_dv", 32'(data_Valid), 0);
        step(0, 1, 0, 0, 8'd0);
        chk("unf_set", 32'(err_Underflow), 1);
        chk("unf_hold", 32'(buffer_Output), 16);
        chk("unf_dv", 32'(data_Valid), 0);
        step(0, 0, 0, 1, 8'd0);
        chk("unf_clr", 32'(err_Underflow), 0);

        // Advance pointers by 10, then wrap with A0..AB
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 8'(8'h10 + i));
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 8'd0);
            chk("p10_out", 32'(buffer_Output), 32'(8'h10 + i));
        end
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 0, 0, 8'(8'hA0 + i));
            if (i == 3) chk("ae_at4", 32'(sig_AlmostEmpty), 1);
            if (i == 4) chk("ae_at5", 32'(sig_AlmostEmpty), 0);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 0, 8'd0);
            chk("wrap_out", 32'(buffer_Output), 32'(8'hA0 + i));
        end
        chk("wrap_empty", 32'(sig_Empty), 1);

        // Simultaneous read/write on full
        for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, 8'(i));
        step(1, 1, 0, 0, 8'h55);
        chk("rw_full_cnt", 32'(fill_Count), 16);
        chk("rw_full_ovf", 32'(err_Overflow), 0);
        chk("rw_full_out", 32'(buffer_Output), 1);
        chk("rw_full_dv", 32'(data_Valid), 1);
        for (int i = 2; i <= 16; i++) begin
            step(0, 1, 0, 0, 8'd0);
            chk("rw_drain", 32'(buffer_Output), 32'(i));
        end
        step(0, 1, 0, 0, 8'd0);
        chk("rw_last", 32'(buffer_Output), 32'h55);
        chk("rw_empty", 32'(sig_Empty), 1);

        // Simultaneous read/write on empty: no bypass
        step(1, 1, 0, 0, 8'h33);
        chk("rw_emp_cnt", 32'(fill_Count), 1);
        chk("rw_emp_unf", 32'(err_Underflow), 1);
        chk("rw_emp_dv", 32'(data_Valid), 0);
        chk("rw_emp_out", 32'(buffer_Output), 32'h55);
        step(0, 1, 0, 0, 8'd0);
        chk("rw_emp_rd", 32'(buffer_Output), 32'h33);
        chk("rw_emp_rdv", 32'(data_Valid), 1);
        step(0, 0, 0, 1, 8'd0);
        chk("rw_emp_clr", 32'(err_Underflow), 0);

        // Flush with 5 stored and a write/read request pending
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'(8'h60 + i));
        chk("pre_flush", 32'(fill_Count), 5);
        step(1, 1, 1, 0, 8'h77);
        chk("flush_cnt", 32'(fill_Count), 0);
        chk("flush_empty", 32'(sig_Empty), 1);
        chk("flush_ovf", 32'(err_Overflow), 0);
        chk("flush_unf", 32'(err_Underflow), 0);
        chk("flush_dv", 32'(data_Valid), 0);
        chk("flush_out", 32'(buffer_Output), 32'h33);

        // Set wins over clear
        step(0, 1, 0, 1, 8'd0);
        chk("setwins", 32'(err_Underflow), 1);
        step(0, 0, 0, 1, 8'd0);
        chk("clr_after", 32'(err_Underflow), 0);

        // Async reset mid-burst with an error pending and data out
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'(8'h80 + i));
        step(0, 1, 0, 0, 8'd0);
        step(0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 0, 8'd0);
        step(0, 1, 0, 0, 8'd0);
        step(0, 1, 0, 0, 8'd0);
        step(0, 1, 0, 0, 8'd0);
        chk("pre_rst_unf", 32'(err_Underflow), 1);
        chk("pre_rst_out", 32'(buffer_Output), 32'h82);
        step(1, 0, 0, 0, 8'h90);
        write_Enable = 1'b1;
        buffer_Input = 8'h91;
        #1;
        reset = 1'b1;
        #1;
        chk_reset_state("midrst");
        write_Enable = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        step(0, 0, 0, 0, 8'd0);
        chk("post_rst_cnt", 32'(fill_Count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
